// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state
// encoding, the bubble word and the sequential PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned PC_INCR  = 4;

endpackage

// File: rtl/program_counter.sv
// PC register with asynchronous active-high reset and a load enable.
// Ports: Clk, Reset, load, next_pc -> pc.
module program_counter
#(
    parameter int          PC_WIDTH = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] next_pc,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc <= PC_WIDTH'(RESET_PC);
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: next-PC selection, BOOT/RUN/HOLD FSM and IF/ID register.
// Ports: Clk, Reset, Stall, BranchTaken/BranchTarget, Jump/JumpTarget,
//   Address -> imem, Instruction <- imem, IFID_Instruction/PCPlus4/Valid.
// Optional macro FETCH_PERF_CNT_EN adds FetchCount and StallCount.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_WIDTH = 32
)
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    input  logic                Jump,
    input  logic [PC_WIDTH-1:0] JumpTarget,
    output logic [PC_WIDTH-1:0] Address,
    input  logic [31:0]         Instruction,
    output logic [31:0]         IFID_Instruction,
    output logic [PC_WIDTH-1:0] IFID_PCPlus4,
    output logic                IFID_Valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         FetchCount,
    output logic [31:0]         StallCount
`endif
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic                active;
    logic                take_br;
    logic                take_jmp;
    logic                do_fetch;
    logic                pc_load;

    // Wraps modulo 2^PC_WIDTH by plain truncation.
    assign seq_pc  = pc + PC_WIDTH'(PC_INCR);
    assign Address = pc;

    // BOOT spends one cycle presenting RESET_PC; nothing is taken then.
    assign active   = (state != BOOT);
    assign take_br  = active & BranchTaken;
    assign take_jmp = active & ~BranchTaken & Jump;
    assign do_fetch = active & ~BranchTaken & ~Jump & ~Stall;
    assign pc_load  = take_br | take_jmp | do_fetch;

    always_comb begin
        next_pc = seq_pc;
        unique case (1'b1)
            take_br:  next_pc = BranchTarget;
            take_jmp: next_pc = JumpTarget;
            default:  next_pc = seq_pc;
        endcase
    end

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clk     (Clk),
        .Reset   (Reset),
        .load    (pc_load),
        .next_pc (next_pc),
        .pc      (pc)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= BOOT;
            IFID_Instruction <= NOP_WORD;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, HOLD: begin
                    if (BranchTaken || Jump) begin
                        // Redirect squashes IF/ID even when stalled.
                        state            <= RUN;
                        IFID_Instruction <= NOP_WORD;
                        IFID_PCPlus4     <= '0;
                        IFID_Valid       <= 1'b0;
                    end else if (Stall) begin
                        state <= HOLD;
                    end else begin
                        state            <= RUN;
                        IFID_Instruction <= Instruction;
                        IFID_PCPlus4     <= seq_pc;
                        IFID_Valid       <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (do_fetch) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (state == HOLD) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit against a
// cycle-level reference model driven with random stimulus.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    logic        w_stall = 1'b0;
    logic        w_br = 1'b0;
    logic        w_jmp = 1'b0;
    logic [31:0] w_tgt = '0;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_ins_q;
    logic [31:0] w_pc4_q;
    logic        w_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
    logic [31:0] w_fc;
    logic [31:0] w_sc;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state (0 = boot, 1 = run, 2 = hold).
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb Instruction = imem(Address);
    always_comb w_instr = imem(w_addr);

    always #5 Clk = ~Clk;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_WIDTH (32)
    ) dut0 (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .Address          (Address),
        .Instruction      (Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount       (FetchCount),
        .StallCount       (StallCount)
`endif
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .PC_WIDTH (32)
    ) dut1 (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (w_stall),
        .BranchTaken      (w_br),
        .BranchTarget     (w_tgt),
        .Jump             (w_jmp),
        .JumpTarget       (w_tgt),
        .Address          (w_addr),
        .Instruction      (w_instr),
        .IFID_Instruction (w_ins_q),
        .IFID_PCPlus4     (w_pc4_q),
        .IFID_Valid       (w_valid_q)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount       (w_fc),
        .StallCount       (w_sc)
`endif
    );

    task automatic m_reset();
        m_state = 0;
        m_pc    = 32'h0;
        m_ins   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fc    = 32'h0;
        m_sc    = 32'h0;
    endtask

    // One clock of the architectural behaviour, from the current inputs.
    task automatic m_step();
        if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 2) m_sc = m_sc + 1;
            if (BranchTaken || Jump) begin
                m_pc    = BranchTaken ? BranchTarget : JumpTarget;
                m_ins   = 32'h0;
                m_pc4   = 32'h0;
                m_valid = 1'b0;
                m_state = 1;
            end else if (Stall) begin
                m_state = 2;
            end else begin
                m_ins   = imem(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
                m_fc    = m_fc + 1;
                m_state = 1;
            end
        end
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic tick();
        m_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        Jump        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1'b1;
        m_reset();
        #3;
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (Address !== 32'h0) begin
            errors++;
            $display("FAIL boot_addr got=%h exp=%h", Address, 32'h0);
        end
        checks++;
        if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 ||
            IFID_PCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL boot_ifid got=%b/%h/%h exp=0/0/0",
                     IFID_Valid, IFID_Instruction, IFID_PCPlus4);
        end
        tick();
        checks++;
        if (Address !== 32'h0 || IFID_Valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_hold got=%h/%b exp=0/0", Address, IFID_Valid);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (Address !== 32'h10) begin
            errors++;
            $display("FAIL run4_addr got=%h exp=%h", Address, 32'h10);
        end
        checks++;
        if (IFID_PCPlus4 !== 32'h10 || IFID_Valid !== 1'b1) begin
            errors++;
            $display("FAIL run4_ifid got=%h/%b exp=10/1",
                     IFID_PCPlus4, IFID_Valid);
        end
        checks++;
        if (IFID_Instruction !== imem(32'hC)) begin
            errors++;
            $display("FAIL run4_instr got=%h exp=%h",
                     IFID_Instruction, imem(32'hC));
        end
    endtask

    task automatic test_stall();
        logic [31:0] s_ins;
        logic [31:0] s_pc4;
        do_reset();
        tick();
        tick();
        tick();
        s_ins = IFID_Instruction;
        s_pc4 = IFID_PCPlus4;
        checks++;
        if (Address !== 32'h8 || s_pc4 !== 32'h8) begin
            errors++;
            $display("FAIL stall_pre got=%h/%h exp=8/8", Address, s_pc4);
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Address !== 32'h8 || IFID_Instruction !== s_ins ||
                IFID_PCPlus4 !== s_pc4 || IFID_Valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h/%h/%h exp=8/%h/%h",
                         i, Address, IFID_Instruction, IFID_PCPlus4,
                         s_ins, s_pc4);
            end
        end
        Stall = 1'b0;
        tick();
        checks++;
        if (Address !== 32'hC || IFID_PCPlus4 !== 32'hC) begin
            errors++;
            $display("FAIL stall_resume got=%h/%h exp=c/c",
                     Address, IFID_PCPlus4);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (StallCount !== 32'd3) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=3", StallCount);
        end
        checks++;
        if (FetchCount !== 32'd3) begin
            errors++;
            $display("FAIL fetch_count got=%0d exp=3", FetchCount);
        end
`endif
    endtask

    task automatic test_branch_vs_jump();
        tick();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h40;
        Jump         = 1'b1;
        JumpTarget   = 32'h80;
        tick();
        clear_inputs();
        checks++;
        if (Address !== 32'h40) begin
            errors++;
            $display("FAIL br_wins got=%h exp=%h", Address, 32'h40);
        end
        checks++;
        if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0) begin
            errors++;
            $display("FAIL br_bubble got=%b/%h exp=0/0",
                     IFID_Valid, IFID_Instruction);
        end
        tick();
        checks++;
        if (Address !== 32'h44 || IFID_PCPlus4 !== 32'h44 ||
            IFID_Instruction !== imem(32'h40)) begin
            errors++;
            $display("FAIL br_follow got=%h/%h/%h exp=44/44/%h",
                     Address, IFID_PCPlus4, IFID_Instruction, imem(32'h40));
        end
    endtask

    task automatic test_redirect_in_stall();
        Stall = 1'b1;
        tick();
        checks++;
        if (dut0.state !== HOLD) begin
            errors++;
            $display("FAIL hold_entry got=%0d exp=%0d", dut0.state, HOLD);
        end
        Jump       = 1'b1;
        JumpTarget = 32'h20;
        tick();
        clear_inputs();
        checks++;
        if (Address !== 32'h20 || IFID_Valid !== 1'b0 ||
            IFID_Instruction !== 32'h0) begin
            errors++;
            $display("FAIL jmp_in_stall got=%h/%b/%h exp=20/0/0",
                     Address, IFID_Valid, IFID_Instruction);
        end
        checks++;
        if (dut0.state !== RUN) begin
            errors++;
            $display("FAIL jmp_state got=%0d exp=%0d", dut0.state, RUN);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++;
        if (w_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_boot got=%h exp=fffffff8", w_addr);
        end
        tick();
        tick();
        checks++;
        if (w_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_fc got=%h exp=fffffffc", w_addr);
        end
        tick();
        checks++;
        if (w_addr !== 32'h0 || w_pc4_q !== 32'h0 || w_valid_q !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero got=%h/%h/%b exp=0/0/1",
                     w_addr, w_pc4_q, w_valid_q);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (Address !== 32'h1C || IFID_Valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_async got=%h/%b exp=1c/1", Address, IFID_Valid);
        end
        #2;
        Reset = 1'b1;
        m_reset();
        #1;
        checks++;
        if (Address !== 32'h0 || IFID_Valid !== 1'b0 ||
            IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL async_rst got=%h/%b/%h/%h exp=0/0/0/0",
                     Address, IFID_Valid, IFID_Instruction, IFID_PCPlus4);
        end
        #1;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        m_state = 1;
        tick();
        checks++;
        if (Address !== 32'h4 || IFID_PCPlus4 !== 32'h4) begin
            errors++;
            $display("FAIL post_async got=%h/%h exp=4/4",
                     Address, IFID_PCPlus4);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r            = $urandom_range(0, 99);
            BranchTaken  = (r < 8);
            r            = $urandom_range(0, 99);
            Jump         = (r < 10);
            r            = $urandom_range(0, 99);
            Stall        = (r < 30);
            BranchTarget = $urandom;
            JumpTarget   = $urandom;
            tick();
            checks++;
            if (Address !== m_pc || IFID_Instruction !== m_ins ||
                IFID_PCPlus4 !== m_pc4 || IFID_Valid !== m_valid) begin
                errors++;
                $display("FAIL rand%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                         i, Address, IFID_Instruction, IFID_PCPlus4,
                         IFID_Valid, m_pc, m_ins, m_pc4, m_valid);
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (FetchCount !== m_fc || StallCount !== m_sc) begin
                errors++;
                $display("FAIL rand_cnt%0d got=%0d/%0d exp=%0d/%0d",
                         i, FetchCount, StallCount, m_fc, m_sc);
            end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        m_reset();
        @(posedge Clk);
        #1;
        test_reset();
        test_stall();
        test_branch_vs_jump();
        test_redirect_in_stall();
        test_random();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch byte address after reset.
REQ-002 SHALL have parameter PC_WIDTH, default 32, meaning the PC and address width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port Clk, input, 1, meaning the clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1, meaning the asynchronous active-high reset.
REQ-006 SHALL have port Stall, input, 1, meaning hold PC and IF/ID contents this cycle.
REQ-007 SHALL have port BranchTaken, input, 1, meaning redirect to BranchTarget.
REQ-008 SHALL have port BranchTarget, input, 32, meaning the branch byte address.
REQ-009 SHALL have port Jump, input, 1, meaning redirect to JumpTarget.
REQ-010 SHALL have port JumpTarget, input, 32, meaning the jump byte address.
REQ-011 SHALL have port Address, output, 32, meaning the byte address driven to InstructionMemory; it equals the current PC.
REQ-012 SHALL have port Instruction, input, 32, meaning the combinational word returned by InstructionMemory for Address.
REQ-013 SHALL have port IFID_Instruction, output, 32, meaning the registered fetched word.
REQ-014 SHALL have port IFID_PCPlus4, output, 32, meaning the registered PC+4 of the fetched word.
REQ-015 SHALL have port IFID_Valid, output, 1, meaning IF/ID holds a real instruction rather than a bubble.

Function
REQ-016 SHALL implement FSM states BOOT, RUN and HOLD.
REQ-017 SHALL transition as follows: BOOT->RUN after one clock; RUN->HOLD when Stall=1 and no redirect; HOLD->RUN when Stall=0 or on a redirect.
REQ-018 SHALL apply per-cycle priority: Reset, then BranchTaken, then Jump, then Stall, then sequential fetch.
REQ-019 SHALL, on BranchTaken: PC<=BranchTarget, IF/ID<=bubble (Instruction 0, Valid 0), even while Stall=1.
REQ-020 SHALL, on Jump with BranchTaken=0: PC<=JumpTarget, IF/ID<=bubble; when both are asserted, the branch wins.
REQ-021 SHALL, on Stall without a redirect: hold PC and all IF/ID outputs unchanged.
REQ-022 SHALL, on sequential fetch: IFID_Instruction<=Instruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, PC<=PC+4.
REQ-023 SHALL produce a fetched word at the IF/ID outputs one clock after its Address is presented.
REQ-024 SHALL compute PC+4 modulo 2^32, so that 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
REQ-025 SHALL, in BOOT, present Address=RESET_PC and keep IFID_Valid=0; the first sequential fetch occurs on entry to RUN.
REQ-026 SHALL pass redirect targets through unaligned; Address[1:0] is forwarded as is.

Reset
REQ-027 SHALL, on Reset assertion at any time including mid-stall or mid-redirect: immediately set PC=RESET_PC, state=BOOT, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, and counters=0.
REQ-028 SHALL release reset cleanly: the first clock after deassertion moves BOOT->RUN.

Configuration
REQ-029 SHALL, with macro FETCH_PERF_CNT_EN defined, add outputs FetchCount[31:0], counting cycles with a sequential fetch, and StallCount[31:0], counting HOLD cycles; both wrap at 2^32.
REQ-030 SHALL, without FETCH_PERF_CNT_EN, omit those ports and their logic entirely.

Structure
REQ-031 SHALL place the following in a shared package fetch_pkg: the state encoding (BOOT, RUN, HOLD), NOP_WORD=32'h00000000, and PC_INCR=4.
REQ-032 SHALL contain one sub-module, program_counter: a PC register with async reset, a load enable and a next-PC input.
REQ-033 SHALL leave next-PC selection, the FSM and the IF/ID register at the top level.

Verification
REQ-034 SHALL verify reset: release Reset with RESET_PC=0 -> Address=0 in BOOT; after 4 run cycles Address=0x10, IFID_PCPlus4=0x10, Valid=1.
REQ-035 SHALL verify stall: assert Stall for 3 cycles at Address=0x8 -> Address stays 0x8, IF/ID unchanged, StallCount=3 when the macro is on.
REQ-036 SHALL verify branch vs jump: BranchTaken=1 with target 0x40 and Jump=1 with target 0x80 in the same cycle -> next Address=0x40, IFID_Valid=0.
REQ-037 SHALL verify redirect during stall: Stall=1 with Jump=1 and target 0x20 -> next Address=0x20, bubble in IF/ID, state RUN.
REQ-038 SHALL verify wrap: RESET_PC=32'hFFFFFFF8 -> Address sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-039 SHALL verify async reset mid-operation: assert Reset between clock edges at Address=0x1C -> Address=RESET_PC and Valid=0 immediately, without waiting for a clock edge.
